mem_resp: RTL

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_resp.sv
// mem_resp: word-addressed memory responder with fixed read latency and request error reporting
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset
//   re_mem_i  read request strobe
//   we_mem_i  write request strobe
//   addr_i    byte address; the word index is addr_i[log2(DEPTH)+1:2]
//   wdata_i   write data
//   rdata_o   last completed read value
//   rvalid_o  one-cycle pulse when rdata_o carries a new read result
//   ready_o   a request can be accepted this cycle
//   err_o     one-cycle pulse after a rejected request
// Optional build macro MEM_RESP_ZERO_INIT_EN: zero the whole array after every reset release.
module mem_resp #(
   parameter int DEPTH    = 256,
   parameter int READ_LAT = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        re_mem_i,
   input  logic        we_mem_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        rvalid_o,
   output logic        ready_o,
   output logic        err_o
);
   localparam int AW = $clog2(DEPTH);
`ifdef MEM_RESP_ZERO_INIT_EN
   typedef enum logic [1:0] {IDLE, WRITE, READ, INIT} state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
`endif
   logic [31:0]   mem [DEPTH];
   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;
   logic          err_q, err_d;
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [31:0]   mem_wd;
   logic [AW-1:0] idx;
   logic          req, bad;
`ifdef MEM_RESP_ZERO_INIT_EN
   logic [AW-1:0] init_q, init_d;
`endif
   assign idx      = addr_i[AW+1:2];
   // ready is masked by reset so nothing is accepted (or written) while rst_i is high
   assign ready_o  = (state_q == IDLE) && !rst_i;
   assign req      = ready_o && (re_mem_i || we_mem_i);
   assign bad      = (addr_i[1:0] != 2'b00) || (addr_i >= 32'(4 * DEPTH)) || (re_mem_i && we_mem_i);
   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      mem_we   = 1'b0;
      mem_wa   = idx;
      mem_wd   = wdata_i;
`ifdef MEM_RESP_ZERO_INIT_EN
      init_d   = init_q;
`endif
      case (state_q)
         IDLE: begin
            if (req && bad) begin
               err_d = 1'b1;
            end else if (req && we_mem_i) begin
               mem_we  = 1'b1;
               state_d = WRITE;
            end else if (req) begin
               state_d = READ;
               cnt_d   = 2'(READ_LAT - 1);
               addr_d  = idx;
            end
         end
         WRITE: state_d = IDLE;
         READ: begin
            // no write can be accepted while a read is pending, so reading at completion is coherent
            if (cnt_q == 2'd0) begin
               state_d  = IDLE;
               rvalid_d = 1'b1;
               rdata_d  = mem[addr_q];
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
`ifdef MEM_RESP_ZERO_INIT_EN
         INIT: begin
            mem_we = 1'b1;
            mem_wa = init_q;
            mem_wd = '0;
            init_d = init_q + 1'b1;
            if (init_q == AW'(DEPTH - 1)) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
`ifdef MEM_RESP_ZERO_INIT_EN
         state_q <= INIT;
         init_q  <= '0;
`else
         state_q <= IDLE;
`endif
         cnt_q    <= '0;
         addr_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
`ifdef MEM_RESP_ZERO_INIT_EN
         init_q <= init_d;
`endif
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) mem[mem_wa] <= mem_wd;
   end
endmodule
